// File: rtl/mult_host_pkg.sv
// Shared types and constants for the mult_host multiplier front-end.
// Holds the controller state encoding and the operand FIFO depth.
package mult_host_pkg;

   localparam int unsigned FIFO_DEPTH   = 2;
   localparam int unsigned NUM_OPERANDS = 4;
   localparam int unsigned TIMER_WIDTH  = 16;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StWaitReady = 3'd1,
      StIssue     = 3'd2,
      StWaitDone  = 3'd3,
      StAck       = 3'd4,
      StOut       = 3'd5
   } state_e;

endpackage

// File: rtl/mult_host_fifo.sv
// Small operand FIFO; a push while full is accepted only if a pop frees a slot
// on the same edge.
module mult_host_fifo
   import mult_host_pkg::*;
#(
   parameter int unsigned DataWidth = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 empty_o,
   output logic                 full_o
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   logic [DataWidth-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]      wptr_q, wptr_d;
   logic [PtrW-1:0]      rptr_q, rptr_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(FIFO_DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) mem_q[wptr_q] <= wdata_i;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/mult_host.sv
// Host-side sequencer for a handshaked multiplier: queues operand sets, issues them,
// collects the product and presents it downstream, aborting stuck operations.
module mult_host
   import mult_host_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iReq_Valid,
   output logic               oReq_Ready,
   input  logic [WIDTH-1:0]   iReq_A,
   input  logic [WIDTH-1:0]   iReq_B,
   input  logic [WIDTH-1:0]   iReq_C,
   input  logic [WIDTH-1:0]   iReq_D,
   output logic               oMul_Valid,
   output logic               oMul_Ack,
   output logic [WIDTH-1:0]   oMul_A,
   output logic [WIDTH-1:0]   oMul_B,
   output logic [WIDTH-1:0]   oMul_C,
   output logic [WIDTH-1:0]   oMul_D,
   input  logic               iMul_Idle,
   input  logic               iMul_Done,
   input  logic [4*WIDTH-1:0] iMul_Result,
   output logic               oRes_Valid,
   input  logic               iRes_Ready,
   output logic [4*WIDTH-1:0] oRes_Data,
   output logic               oTimeout
);

   localparam int unsigned OpsW = NUM_OPERANDS * WIDTH;

   state_e                 state_q, state_d;
   logic                   init_q;
   logic [OpsW-1:0]        ops_q, ops_d;
   logic [4*WIDTH-1:0]     res_q, res_d;
   logic [TIMER_WIDTH-1:0] tmr_q, tmr_d;
   logic                   timeout_q, timeout_d;

   logic                   fifo_push, fifo_pop;
   logic                   fifo_empty, fifo_full;
   logic [OpsW-1:0]        fifo_wdata, fifo_rdata;

   // init_q holds ready low until the first edge after reset is released.
   assign oReq_Ready = init_q && !fifo_full;
   assign fifo_push  = iReq_Valid && oReq_Ready;
   assign fifo_wdata = {iReq_A, iReq_B, iReq_C, iReq_D};

   assign oMul_A    = ops_q[4*WIDTH-1:3*WIDTH];
   assign oMul_B    = ops_q[3*WIDTH-1:2*WIDTH];
   assign oMul_C    = ops_q[2*WIDTH-1:WIDTH];
   assign oMul_D    = ops_q[WIDTH-1:0];
   assign oRes_Data = res_q;
   assign oTimeout  = timeout_q;

   mult_host_fifo #(
      .DataWidth (OpsW)
   ) u_fifo (
      .clk_i   (Clock),
      .rst_i   (Reset),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_comb begin
      state_d    = state_q;
      ops_d      = ops_q;
      res_d      = res_q;
      tmr_d      = tmr_q;
      timeout_d  = 1'b0;
      fifo_pop   = 1'b0;
      oMul_Valid = 1'b0;
      oMul_Ack   = 1'b0;
      oRes_Valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               ops_d    = fifo_rdata;
               state_d  = StWaitReady;
            end
         end
         StWaitReady: begin
            if (iMul_Idle && !iMul_Done) state_d = StIssue;
         end
         StIssue: begin
            oMul_Valid = 1'b1;
            if (!iMul_Idle || iMul_Done) begin
               tmr_d   = '0;
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (iMul_Done) begin
               res_d   = iMul_Result;
               state_d = StAck;
            end else if (tmr_q == TIMER_WIDTH'(TIMEOUT - 1)) begin
               // TIMEOUT cycles spent here with no Done: drop the operation.
               tmr_d     = tmr_q + TIMER_WIDTH'(1);
               timeout_d = 1'b1;
               state_d   = StIdle;
            end else begin
               tmr_d = tmr_q + TIMER_WIDTH'(1);
            end
         end
         StAck: begin
            oMul_Ack = 1'b1;
            if (!iMul_Done) state_d = StOut;
         end
         StOut: begin
            oRes_Valid = 1'b1;
            if (iRes_Ready) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  ops_d    = fifo_rdata;
                  state_d  = StWaitReady;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= StIdle;
         init_q    <= 1'b0;
         ops_q     <= '0;
         res_q     <= '0;
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= 1'b1;
         ops_q     <= ops_d;
         res_q     <= res_d;
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_mult_host.sv
// Self-checking bench for mult_host: fixed vectors, corner-case sequences and a
// randomized run against a product scoreboard driven by a behavioural multiplier.
module tb_mult_host;

   localparam int unsigned W  = 16;
   localparam int unsigned TO = 16;
   localparam int unsigned RW = 4 * W;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic          iReq_Valid = 1'b0;
   logic          oReq_Ready;
   logic [W-1:0]  iReq_A = '0, iReq_B = '0, iReq_C = '0, iReq_D = '0;
   logic          oMul_Valid, oMul_Ack;
   logic [W-1:0]  oMul_A, oMul_B, oMul_C, oMul_D;
   logic          iMul_Idle = 1'b1, iMul_Done = 1'b0;
   logic [RW-1:0] iMul_Result = '0;
   logic          oRes_Valid;
   logic          iRes_Ready = 1'b1;
   logic [RW-1:0] oRes_Data;
   logic          oTimeout;

   mult_host #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iReq_Valid  (iReq_Valid),
      .oReq_Ready  (oReq_Ready),
      .iReq_A      (iReq_A),
      .iReq_B      (iReq_B),
      .iReq_C      (iReq_C),
      .iReq_D      (iReq_D),
      .oMul_Valid  (oMul_Valid),
      .oMul_Ack    (oMul_Ack),
      .oMul_A      (oMul_A),
      .oMul_B      (oMul_B),
      .oMul_C      (oMul_C),
      .oMul_D      (oMul_D),
      .iMul_Idle   (iMul_Idle),
      .iMul_Done   (iMul_Done),
      .iMul_Result (iMul_Result),
      .oRes_Valid  (oRes_Valid),
      .iRes_Ready  (iRes_Ready),
      .oRes_Data   (oRes_Data),
      .oTimeout    (oTimeout)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [W-1:0]  a, b, c, d;
      logic [RW-1:0] exp;
   } vec_t;

   vec_t          vecs [6];
   int            checks = 0, failures = 0;
   logic [RW-1:0] expq [$];
   logic [RW-1:0] res_log [$];
   int            res_count = 0, push_count = 0;
   logic [RW-1:0] last_res = '0;
   bit            pushed = 1'b0;
   int            mulv_rises = 0, ack_rises = 0, both_hi = 0, op_viol = 0, to_pulses = 0;
   bit            prev_mulv = 1'b0, prev_ack = 1'b0;
   // Responder: mode 0 normal, 1 never finishes, 2 keeps Done high regardless of Ack.
   bit            rsp_busy = 1'b0;
   int            rsp_cnt = 0, rsp_mode = 0, rsp_maxlat = 2;
   logic [RW-1:0] rsp_res = '0, rsp_ops = '0;

   function automatic logic [RW-1:0] prod(input logic [W-1:0] a, b, c, d);
      return RW'(a) * RW'(b) * RW'(c) * RW'(d);
   endfunction

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic rsp_reset();
      iMul_Idle   = 1'b1;
      iMul_Done   = 1'b0;
      iMul_Result = '0;
      rsp_busy    = 1'b0;
      rsp_mode    = 0;
   endtask

   // One clock: log the handshakes the coming edge will see, then react at the falling edge.
   task automatic step();
      pushed = 1'b0;
      if (iReq_Valid && oReq_Ready) begin
         expq.push_back(prod(iReq_A, iReq_B, iReq_C, iReq_D));
         pushed = 1'b1;
         push_count++;
      end
      if (oRes_Valid && iRes_Ready) begin
         res_count++;
         last_res = oRes_Data;
         res_log.push_back(oRes_Data);
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stale_result: got %0h required no result", oRes_Data);
         end else begin
            chk("scoreboard", oRes_Data, expq.pop_front());
         end
      end
      @(negedge Clock);
      if (!rsp_busy) begin
         if (oMul_Valid && iMul_Idle) begin
            rsp_busy  = 1'b1;
            iMul_Idle = 1'b0;
            rsp_ops   = {oMul_A, oMul_B, oMul_C, oMul_D};
            rsp_res   = prod(oMul_A, oMul_B, oMul_C, oMul_D);
            rsp_cnt   = int'($urandom_range(rsp_maxlat, 0));
         end
      end else if (!iMul_Done) begin
         if (rsp_mode != 1) begin
            if (rsp_cnt == 0) begin
               iMul_Done   = 1'b1;
               iMul_Result = rsp_res;
            end else begin
               rsp_cnt--;
            end
         end
      end else if (oMul_Ack && rsp_mode != 2) begin
         iMul_Done   = 1'b0;
         iMul_Idle   = 1'b1;
         rsp_busy    = 1'b0;
         iMul_Result = {$urandom, $urandom};
      end
      if (rsp_busy && {oMul_A, oMul_B, oMul_C, oMul_D} !== rsp_ops) op_viol++;
      if (oMul_Valid && oMul_Ack) both_hi++;
      if (oMul_Valid && !prev_mulv) mulv_rises++;
      if (oMul_Ack && !prev_ack) ack_rises++;
      if (oTimeout) to_pulses++;
      prev_mulv = oMul_Valid;
      prev_ack  = oMul_Ack;
   endtask

   task automatic push(input logic [W-1:0] a, b, c, d);
      iReq_A = a; iReq_B = b; iReq_C = c; iReq_D = d;
      iReq_Valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         step();
         if (pushed) begin
            iReq_Valid = 1'b0;
            return;
         end
      end
      iReq_Valid = 1'b0;
      chk("push_accepted", RW'(0), RW'(1));
   endtask

   task automatic wait_results(input int target, input string name);
      for (int n = 0; n < 2000 && res_count < target; n++) step();
      chk(name, RW'(res_count), RW'(target));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, RW'(oReq_Ready), RW'(0));
      chk({tag, "_mul_valid"}, RW'(oMul_Valid), RW'(0));
      chk({tag, "_mul_ack"}, RW'(oMul_Ack), RW'(0));
      chk({tag, "_res_valid"}, RW'(oRes_Valid), RW'(0));
      chk({tag, "_timeout"}, RW'(oTimeout), RW'(0));
      chk({tag, "_res_data"}, oRes_Data, RW'(0));
      chk({tag, "_mul_ops"}, {oMul_A, oMul_B, oMul_C, oMul_D}, RW'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish required finish within budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat, n, base, start_res, start_push, changes;
      logic [RW-1:0] held;

      vecs[0] = '{16'd1, 16'd2, 16'd3, 16'd4, 64'd24};
      vecs[1] = '{16'd2, 16'd3, 16'd4, 16'd5, 64'd120};
      vecs[2] = '{16'd0, 16'd7, 16'd8, 16'd9, 64'd0};
      vecs[3] = '{16'h0100, 16'h0100, 16'd1, 16'd1, 64'h1_0000};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'hFFFC_0005_FFFC_0001};
      vecs[5] = '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 64'd1000000000000};

      // Reset state and ready release.
      #1 Reset = 1'b1;
      #1 chk_all_zero("reset");
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      #1 chk("ready_before_edge", RW'(oReq_Ready), RW'(0));
      step();
      chk("ready_after_edge", RW'(oReq_Ready), RW'(1));

      // Table vectors; the first also checks issue latency and handshake counts.
      for (int i = 0; i < 6; i++) begin
         mulv_rises = 0;
         ack_rises  = 0;
         push(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
         if (i == 0) begin
            lat = 0;
            while (!oMul_Valid && lat < 20) begin
               step();
               lat++;
            end
            chk("issue_latency", RW'(lat), RW'(2));
         end
         wait_results(res_count + 1, "vec_done");
         chk($sformatf("vec%0d_product", i), last_res, vecs[i].exp);
         if (i == 0) begin
            chk("vec0_valid_pulses", RW'(mulv_rises), RW'(1));
            chk("vec0_ack_episodes", RW'(ack_rises), RW'(1));
         end
      end

      // Back-to-back pushes fill the FIFO behind the first in-flight set.
      rsp_maxlat = 3;
      base = res_count;
      n = push_count;
      iReq_Valid = 1'b1;
      iReq_A = 16'd1; iReq_B = 16'd2; iReq_C = 16'd3; iReq_D = 16'd4;
      step();
      iReq_A = 16'd2; iReq_B = 16'd3; iReq_C = 16'd4; iReq_D = 16'd5;
      step();
      iReq_A = 16'd3; iReq_B = 16'd4; iReq_C = 16'd5; iReq_D = 16'd6;
      step();
      iReq_Valid = 1'b0;
      chk("b2b_accepted", RW'(push_count - n), RW'(3));
      chk("b2b_ready_low", RW'(oReq_Ready), RW'(0));
      wait_results(base + 3, "b2b_done");
      chk("b2b_res0", res_log[base], 64'd24);
      chk("b2b_res1", res_log[base + 1], 64'd120);
      chk("b2b_res2", res_log[base + 2], 64'd360);

      // Downstream stall for 50 cycles with another set queued.
      iRes_Ready = 1'b0;
      base = res_count;
      push(16'd7, 16'd8, 16'd9, 16'd10);
      for (int k = 0; k < 200 && !oRes_Valid; k++) step();
      chk("stall_res_valid", RW'(oRes_Valid), RW'(1));
      push(16'd1, 16'd1, 16'd1, 16'd2);
      held = oRes_Data;
      mulv_rises = 0;
      changes = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (oRes_Data !== held || !oRes_Valid) changes++;
      end
      chk("stall_data_stable", RW'(changes), RW'(0));
      chk("stall_no_issue", RW'(mulv_rises), RW'(0));
      chk("stall_product", held, 64'd5040);
      iRes_Ready = 1'b1;
      wait_results(base + 2, "stall_done");
      chk("after_stall_product", last_res, 64'd2);

      // Multiplier that never finishes: abort after TIMEOUT cycles in the wait state.
      rsp_mode = 1;
      to_pulses = 0;
      base = res_count;
      push(16'd9, 16'd9, 16'd9, 16'd9);
      for (int k = 0; k < 50 && !oMul_Valid; k++) step();
      n = 0;
      do begin
         step();
         n++;
      end while (!oTimeout && n < 60);
      chk("timeout_delay", RW'(n), RW'(TO + 1));
      rsp_reset();
      expq.delete();
      step();
      chk("timeout_one_cycle", RW'(oTimeout), RW'(0));
      repeat (5) step();
      chk("timeout_pulses", RW'(to_pulses), RW'(1));
      chk("timeout_no_result", RW'(res_count), RW'(base));
      push(16'd2, 16'd2, 16'd2, 16'd2);
      wait_results(base + 1, "post_timeout_done");
      chk("post_timeout_product", last_res, 64'd16);

      // Asynchronous reset while acknowledging.
      rsp_mode = 2;
      push(16'd3, 16'd3, 16'd3, 16'd3);
      for (int k = 0; k < 100 && !oMul_Ack; k++) step();
      chk("reached_ack", RW'(oMul_Ack), RW'(1));
      Reset = 1'b1;
      #1 chk_all_zero("ack_reset");
      expq.delete();
      rsp_reset();
      step();
      Reset = 1'b0;
      base = res_count;
      repeat (10) step();
      chk("no_stale_result", RW'(res_count), RW'(base));
      push(16'd5, 16'd5, 16'd5, 16'd5);
      wait_results(base + 1, "post_reset_done");
      chk("post_reset_product", last_res, 64'd625);

      // Randomized traffic against the scoreboard.
      rsp_maxlat = 4;
      start_res = res_count;
      start_push = push_count;
      pushed = 1'b0;
      iReq_Valid = 1'b0;
      for (int k = 0; k < 20000 && res_count < start_res + 40; k++) begin
         iRes_Ready = ($urandom_range(3, 0) != 0);
         if (pushed || !iReq_Valid) begin
            iReq_Valid = (push_count < start_push + 40) && ($urandom_range(2, 0) != 0);
            iReq_A = W'($urandom);
            iReq_B = W'($urandom);
            iReq_C = W'($urandom);
            iReq_D = W'($urandom);
         end
         step();
      end
      iReq_Valid = 1'b0;
      iRes_Ready = 1'b1;
      chk("rand_results", RW'(res_count - start_res), RW'(40));
      chk("rand_queue_drained", RW'(expq.size()), RW'(0));

      chk("valid_ack_overlap", RW'(both_hi), RW'(0));
      chk("operand_hold", RW'(op_viol), RW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
